ahb_cmd_master: RTL

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

---
 rtl/ahb_cmd_master.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb_cmd_master.sv
// AHB-Lite command master: issues single NONSEQ transfers from a command port,
// pipelines address/data phases, and handles wait states, ERROR and misalignment.
module ahb_cmd_master #(
  parameter int unsigned AWIDTH    = 10,
  parameter bit          ALIGN_CHK = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              HSEL,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int unsigned DW            = 32;
  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_WAIT = 2'd1,
    D_ERR  = 2'd2
  } dstate_e;

  dstate_e           d_state_q, d_state_d;

  logic              a_valid_q, a_valid_d;
  logic              a_write_q, a_write_d;
  logic [AWIDTH-1:0] a_addr_q,  a_addr_d;
  logic [2:0]        a_size_q,  a_size_d;
  logic [DW-1:0]     a_wdata_q, a_wdata_d;

  logic              d_write_q, d_write_d;
  logic [DW-1:0]     d_wdata_q, d_wdata_d;

  logic              loc_pend_q,  loc_pend_d;
  logic              loc_write_q, loc_write_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;

  logic              addr_cancel;
  logic              addr_done;
  logic              cmd_fire;
  logic              cmd_misalign;
  logic              loc_safe;

  // A pending address phase is suppressed during the second ERROR cycle
  assign addr_cancel = (d_state_q == D_ERR);
  assign addr_done   = a_valid_q && !addr_cancel && HREADY && !HRESP;

  // A queued local error blocks new commands so responses stay in order
  assign cmd_ready = HRESETN && !loc_pend_q && (!a_valid_q || addr_done);
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign cmd_misalign = ALIGN_CHK &&
                        ((cmd_size > 3'd2) ||
                         ((cmd_size == 3'd1) && cmd_addr[0]) ||
                         ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00)));

  // Local errors may respond only when no earlier bus transfer remains
  assign loc_safe = !a_valid_q && (d_state_q == D_IDLE);

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      d_state_q   <= D_IDLE;
      a_valid_q   <= 1'b0;
      a_write_q   <= 1'b0;
      a_addr_q    <= '0;
      a_size_q    <= 3'b000;
      a_wdata_q   <= '0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      loc_pend_q  <= 1'b0;
      loc_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      d_state_q   <= d_state_d;
      a_valid_q   <= a_valid_d;
      a_write_q   <= a_write_d;
      a_addr_q    <= a_addr_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      loc_pend_q  <= loc_pend_d;
      loc_write_q <= loc_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    d_state_d   = d_state_q;
    a_valid_d   = a_valid_q;
    a_write_d   = a_write_q;
    a_addr_d    = a_addr_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    loc_pend_d  = loc_pend_q;
    loc_write_d = loc_write_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    // Data phase: completion, wait states and the two-cycle ERROR response
    unique case (d_state_q)
      D_IDLE: begin
        d_state_d = D_IDLE;
      end
      D_WAIT: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = d_write_q;
          rsp_err_d   = HRESP;
          rsp_rdata_d = (HRESP || d_write_q) ? '0 : HRDATA;
          d_state_d   = D_IDLE;
        end else if (HRESP) begin
          d_state_d = D_ERR;
        end
      end
      D_ERR: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = d_write_q;
          rsp_err_d   = 1'b1;
          d_state_d   = D_IDLE;
        end
      end
      default: begin
        d_state_d = D_IDLE;
      end
    endcase

    // Address phase accepted by the slave moves into the data phase
    if (addr_done) begin
      d_state_d = D_WAIT;
      d_write_d = a_write_q;
      d_wdata_d = a_write_q ? a_wdata_q : '0;
      a_valid_d = 1'b0;
    end

    if (loc_pend_q && loc_safe) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = loc_write_q;
      rsp_err_d   = 1'b1;
      loc_pend_d  = 1'b0;
    end

    if (cmd_fire) begin
      if (cmd_misalign) begin
        if (loc_safe) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = cmd_write;
          rsp_err_d   = 1'b1;
        end else begin
          loc_pend_d  = 1'b1;
          loc_write_d = cmd_write;
        end
      end else begin
        a_valid_d = 1'b1;
        a_write_d = cmd_write;
        a_addr_d  = cmd_addr;
        a_size_d  = cmd_size;
        a_wdata_d = cmd_wdata;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  assign HSEL      = a_valid_q;
  assign HTRANS    = (a_valid_q && !addr_cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HWDATA    = d_wdata_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;

endmodule
